// File: rtl/idle_timer_bank.sv
// idle_timer_bank: a bank of NUM_CH independent idle timers. Each channel
// counts cycles without activity while its session is active (start high)
// and latches a sticky expiry flag when the count reaches the timeout that
// was sampled when the session began. A kick pulse restarts the count.
// Optional feature macro: IDLE_TIMER_WARN_EN enables the registered
// pre-expiry warning outputs; without it, warn is tied low.
module idle_timer_bank #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned WARN_CYC = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] start,
    input  logic [NUM_CH-1:0] kick,
    input  logic [CNT_W-1:0]  timeout,
    output logic [NUM_CH-1:0] time_up,
    output logic [NUM_CH-1:0] warn,
    output logic              any_time_up
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_EXPIRED
    } state_t;

    state_t            state_q [NUM_CH];
    state_t            state_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q   [NUM_CH];
    logic [CNT_W-1:0]  cnt_d   [NUM_CH];
    logic [CNT_W-1:0]  lim_q   [NUM_CH];
    logic [CNT_W-1:0]  lim_d   [NUM_CH];
    logic [NUM_CH-1:0] time_up_d;

    // Per-channel next state: start low dominates, kick beats expiry.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            lim_d[i]   = lim_q[i];
            if (!start[i]) begin
                state_d[i] = S_IDLE;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    S_IDLE: begin
                        state_d[i] = S_RUN;
                        cnt_d[i]   = CNT_W'(1);
                        lim_d[i]   = (timeout == '0) ? CNT_W'(1) : timeout;
                    end
                    S_RUN: begin
                        if (kick[i]) begin
                            cnt_d[i] = CNT_W'(1);
                        end else if (cnt_q[i] == lim_q[i]) begin
                            state_d[i] = S_EXPIRED;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d[i] = state_q[i];
                    end
                endcase
            end
            time_up_d[i] = (state_d[i] == S_EXPIRED);
        end
    end

    // Channel state, counters, limits and the registered expiry flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= '0;
                lim_q[i]   <= '0;
            end
            time_up     <= '0;
            any_time_up <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                lim_q[i]   <= lim_d[i];
            end
            time_up     <= time_up_d;
            any_time_up <= |time_up_d;
        end
    end

`ifdef IDLE_TIMER_WARN_EN
    // WARN_CYC clamped to the counter range so the threshold saturates at 0.
    localparam logic [63:0]      CNT_MAX = (64'd1 << CNT_W) - 64'd1;
    localparam logic [CNT_W-1:0] WARN_C  = (64'(WARN_CYC) > CNT_MAX) ? '1 : CNT_W'(WARN_CYC);

    logic [CNT_W-1:0]  warn_thr [NUM_CH];
    logic [NUM_CH-1:0] warn_d;

    // Warning condition evaluated on next-state values so warn is registered.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            warn_thr[i] = (lim_d[i] > WARN_C) ? (lim_d[i] - WARN_C) : '0;
            warn_d[i]   = (state_d[i] == S_RUN) && (cnt_d[i] >= warn_thr[i]);
        end
    end

    // Warning flag register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            warn <= '0;
        end else begin
            warn <= warn_d;
        end
    end
`else
    assign warn = '0;
`endif

endmodule
